// File: rtl/puf_response_collector.sv
// Sequencer and majority-vote collector for a bank of pico_puf cells sharing one clear line.
// Each evaluation clears, releases, settles and samples all cells; VOTES evaluations form one response.

module puf_vote_lane #(
  parameter int VOTES = 7
) (
  input  logic clk,
  input  logic clear,
  input  logic din,
  input  logic zero,
  input  logic sample,
  input  logic last_vote,
  output logic resp,
  output logic unstable
);
  localparam int OW = $clog2(VOTES + 1);
  localparam logic [OW-1:0] HALF = OW'(VOTES / 2);
  localparam logic [OW-1:0] FULL = OW'(VOTES);

  logic          s1, s2;
  logic [OW-1:0] ones, ones_nxt;

  // count never exceeds VOTES, so OW bits cannot overflow
  assign ones_nxt = ones + OW'(s2);

  always_ff @(posedge clk) begin
    if (!clear) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      ones     <= '0;
      resp     <= 1'b0;
      unstable <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (zero)
        ones <= '0;
      else if (sample)
        ones <= ones_nxt;
      // results include the final sample, hence ones_nxt rather than ones
      if (sample && last_vote) begin
        resp     <= (ones_nxt > HALF);
        unstable <= (ones_nxt != '0) && (ones_nxt != FULL);
      end
    end
  end
endmodule

module puf_response_collector #(
  parameter int NBITS   = 8,
  parameter int VOTES   = 7,
  parameter int CLR_CYC = 4,
  parameter int SETTLE  = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [NBITS-1:0] puf_o,
  output logic             puf_clear,
  output logic             busy,
  output logic [NBITS-1:0] resp,
  output logic [NBITS-1:0] unstable,
  output logic             resp_valid,
  input  logic             resp_ready
);
  localparam int VW   = $clog2(VOTES + 1);
  localparam int CMAX = (CLR_CYC > SETTLE) ? CLR_CYC : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [VW-1:0] vote_cnt;
  logic [CW-1:0] cyc;
  logic          zero, sample, last_vote;

  always_ff @(posedge clk) begin
    if (!clear) begin
      state    <= S_IDLE;
      vote_cnt <= '0;
      cyc      <= '0;
    end else begin
      state <= state_nxt;
      if (zero)
        vote_cnt <= '0;
      else if (sample)
        vote_cnt <= vote_cnt + 1'b1;
      // cyc counts cycles spent in the current timed phase
      if (state_nxt != state || !(state inside {S_CLR, S_SETTLE}))
        cyc <= '0;
      else
        cyc <= cyc + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    zero       = 1'b0;
    sample     = 1'b0;
    last_vote  = (vote_cnt == VW'(VOTES - 1));
    puf_clear  = 1'b1;
    busy       = (state != S_IDLE);
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CLR;
          zero      = 1'b1;
        end
      end
      S_CLR: begin
        if (cyc == CW'(CLR_CYC - 1))
          state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        puf_clear = 1'b0;
        if (cyc == CW'(SETTLE - 1))
          state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        puf_clear = 1'b0;
        sample    = 1'b1;
        state_nxt = last_vote ? S_DONE : S_CLR;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  for (genvar i = 0; i < NBITS; i++) begin : g_lane
    puf_vote_lane #(.VOTES(VOTES)) u_lane (
      .clk      (clk),
      .clear    (clear),
      .din      (puf_o[i]),
      .zero     (zero),
      .sample   (sample),
      .last_vote(last_vote),
      .resp     (resp[i]),
      .unstable (unstable[i])
    );
  end
endmodule

// File: tb/tb_puf_response_collector.sv
// Table-driven bench with a response scoreboard for puf_response_collector,
// plus directed sequences for backpressure, mid-run reset, restart and a VOTES=1 instance.

module tb_puf_response_collector;
  logic       clk = 1'b0;
  logic       clear, start, resp_ready;
  logic [7:0] puf_o;
  logic       puf_clear, busy, resp_valid;
  logic [7:0] resp, unstable;

  logic       start2, resp_ready2;
  logic [7:0] puf_o2;
  logic       puf_clear2, busy2, resp_valid2;
  logic [7:0] resp2, unstable2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  puf_response_collector dut (
    .clk(clk), .clear(clear), .start(start), .puf_o(puf_o),
    .puf_clear(puf_clear), .busy(busy), .resp(resp), .unstable(unstable),
    .resp_valid(resp_valid), .resp_ready(resp_ready)
  );

  puf_response_collector #(.NBITS(8), .VOTES(1), .CLR_CYC(1), .SETTLE(2)) dut2 (
    .clk(clk), .clear(clear), .start(start2), .puf_o(puf_o2),
    .puf_clear(puf_clear2), .busy(busy2), .resp(resp2), .unstable(unstable2),
    .resp_valid(resp_valid2), .resp_ready(resp_ready2)
  );

  typedef struct {
    logic [6:0][7:0] votes;
    logic [7:0]      resp;
    logic [7:0]      unst;
  } vec_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] u;
  } exp_t;

  vec_t tbl[7];
  exp_t sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives start in the current cycle (cycle 0), walks the run, and returns
  // at the negedge of the first cycle with resp_valid high.
  task automatic start_run(input vec_t v, input bit chk_clear);
    exp_t e;
    exp_t got;
    bit   seen = 0;
    e.r = v.resp;
    e.u = v.unst;
    sbq.push_back(e);
    start = 1'b1;
    puf_o = v.votes[0];
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) check("busy_rise", busy, 1);
      if (chk_clear && c <= 147)
        check($sformatf("puf_clear_c%0d", c), puf_clear, ((c - 1) % 21) < 4);
      if (resp_valid) begin
        seen = 1;
        check("valid_cycle", c, 148);
        got = sbq.pop_front();
        check("resp", resp, got.r);
        check("unstable", unstable, got.u);
        break;
      end
      puf_o = v.votes[(c - 1) / 21];
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL valid_timeout: resp_valid never rose, expected at cycle 148");
      void'(sbq.pop_front());
    end
  endtask

  initial begin
    vec_t v;
    tbl[0].votes = {7{8'hFF}};                                      tbl[0].resp = 8'hFF; tbl[0].unst = 8'h00;
    tbl[1].votes = {8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 8'h03, 8'h03}; tbl[1].resp = 8'h01; tbl[1].unst = 8'h03;
    tbl[2].votes = {7{8'hA5}};                                      tbl[2].resp = 8'hA5; tbl[2].unst = 8'h00;
    tbl[3].votes = {7{8'h00}};                                      tbl[3].resp = 8'h00; tbl[3].unst = 8'h00;
    tbl[4].votes = {8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'hF0, 8'hF0, 8'hF0}; tbl[4].resp = 8'h0F; tbl[4].unst = 8'hFF;
    tbl[5].votes = {8'h81, 8'h81, 8'h81, 8'h80, 8'h81, 8'h81, 8'h81}; tbl[5].resp = 8'h81; tbl[5].unst = 8'h01;
    tbl[6].votes = {8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55}; tbl[6].resp = 8'h55; tbl[6].unst = 8'hFF;

    clear = 1'b0; start = 1'b0; resp_ready = 1'b0; puf_o = 8'h00;
    start2 = 1'b0; resp_ready2 = 1'b0; puf_o2 = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_puf_clear", puf_clear, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_resp", resp, 0);
    check("rst_unstable", unstable, 0);
    check("rst_valid2", resp_valid2, 0);
    clear = 1'b1;
    @(negedge clk);

    // VOTES=1 instance: valid at cycle 5
    begin
      bit seen = 0;
      puf_o2 = 8'h3C;
      start2 = 1'b1;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        start2 = 1'b0;
        if (resp_valid2) begin
          seen = 1;
          check("v1_valid_cycle", c, 5);
          check("v1_resp", resp2, 8'h3C);
          check("v1_unstable", unstable2, 8'h00);
          break;
        end
      end
      if (!seen) begin
        n_cmp++;
        n_err++;
        $display("FAIL v1_timeout: resp_valid never rose, expected at cycle 5");
      end
      resp_ready2 = 1'b1;
      @(negedge clk);
      resp_ready2 = 1'b0;
      check("v1_valid_drop", resp_valid2, 0);
    end

    for (int i = 0; i < 7; i++) begin
      start_run(tbl[i], i == 0);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check($sformatf("hs_valid_%0d", i), resp_valid, 0);
      check($sformatf("hs_busy_%0d", i), busy, 0);
    end

    // backpressure with ignored start pulses
    start_run(tbl[1], 0);
    for (int i = 0; i < 10; i++) begin
      start = (i == 2 || i == 5);
      @(negedge clk);
      check($sformatf("bp_valid_%0d", i), resp_valid, 1);
      check($sformatf("bp_resp_%0d", i), resp, 8'h01);
      check($sformatf("bp_unst_%0d", i), unstable, 8'h03);
    end
    start = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp_valid_drop", resp_valid, 0);
    check("bp_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_norun_%0d", i), busy, 0);
    end

    // reset during vote 3 SETTLE (cycle 50)
    start = 1'b1;
    puf_o = 8'hFF;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_busy_before", busy, 1);
    check("mid_clear_low", puf_clear, 0);
    clear = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    check("mid_puf_clear", puf_clear, 1);
    check("mid_busy", busy, 0);
    check("mid_valid", resp_valid, 0);
    check("mid_resp", resp, 0);
    v.votes = {7{8'hA5}};
    v.resp  = 8'hA5;
    v.unst  = 8'h00;
    start_run(v, 0);

    // start in the handshake cycle is dropped; start one cycle later is taken
    resp_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("b2b_busy_idle", busy, 0);
    check("b2b_valid", resp_valid, 0);
    start_run(tbl[4], 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("b2b_final_valid", resp_valid, 0);

    check("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/puf_response_collector.md
Name: puf_response_collector

Overview:
- Downstream consumer and sequencer for a bank of NBITS pico_puf cells sharing one clear line.
- Repeatedly clears and releases the cells, samples each cell's O after a settle window, and majority-votes VOTES evaluations per bit.
- Presents an NBITS response word plus an instability mask on a valid/ready interface to the key/ID logic.

Parameters:
- NBITS, 8, number of PUF cells / response width.
- VOTES, 7, evaluations per response; must be odd, range 1..255.
- CLR_CYC, 4, cycles puf_clear is held high per evaluation; must be at least 1.
- SETTLE, 16, cycles after puf_clear release before sampling; must be at least 2, which covers the synchroniser.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- clear  in  1  synchronous active-low reset.
- start  in  1  request one response; sampled only in IDLE.
- puf_o  in  NBITS  O outputs of the PUF cells (asynchronous).
- puf_clear  out  1  shared clear to the PUF cells; active-high, asserted holds the cells cleared.
- busy  out  1  high whenever state is not IDLE.
- resp  out  NBITS  majority-voted response.
- unstable  out  NBITS  bit i is high if cell i did not agree on all VOTES samples.
- resp_valid  out  1  resp/unstable valid.
- resp_ready  in  1  consumer accepts the response.

Behaviour:
- Reset (clear=0 at a rising edge):
  - State goes to IDLE.
  - Vote counter and per-bit ones counters go to 0; synchroniser flops go to 0.
  - resp=0, unstable=0, resp_valid=0, busy=0, puf_clear=1.
  - Reset applies in any state, including mid-evaluation: the next cycle is IDLE and partial counts are discarded.
- Input synchronisation: puf_o passes through a 2-flop synchroniser per bit. The value counted in SAMPLE is puf_o as it was 2 cycles earlier.
- Ones counters are per bit, clog2(VOTES+1) bits wide, and saturation-free by construction.
- State machine, states IDLE, CLR, SETTLE, SAMPLE, DONE:
  - IDLE: puf_clear=1, busy=0. If start=1, go to CLR and zero all counters.
  - CLR: puf_clear=1 for exactly CLR_CYC cycles, then go to SETTLE.
  - SETTLE: puf_clear=0 for exactly SETTLE cycles, then go to SAMPLE.
  - SAMPLE: one cycle, puf_clear=0. Add each synchronised bit to its ones counter and increment the vote counter.
    - If this was vote VOTES, register the results and go to DONE; otherwise go to CLR.
    - Registered results: resp[i] = (ones_i > VOTES/2); unstable[i] = (ones_i != 0 && ones_i != VOTES). Both include the current sample.
  - DONE: resp_valid=1, puf_clear=1. resp and unstable are held constant. When resp_ready=1, go to IDLE with resp_valid=0 the next cycle; resp and unstable keep their last values.
- Timing:
  - Each evaluation takes CLR_CYC+SETTLE+1 cycles.
  - With start seen in IDLE at cycle 0, the SAMPLE of vote k is at cycle k*(CLR_CYC+SETTLE+1).
  - resp_valid is first high at cycle VOTES*(CLR_CYC+SETTLE+1)+1. With defaults this is cycle 148.
- Simultaneous and ignored events:
  - start outside IDLE is ignored and not queued. This includes start in the same cycle as the resp_ready handshake.
  - resp_ready outside DONE is ignored.
- Minimum restart: a new start is accepted one cycle after the handshake, once the state is back in IDLE.

Test Plan:
- puf_o=8'hFF held constant, start pulse at cycle 0:
  - puf_clear is 1 for cycles 1-4 and 0 for cycles 5-21, repeating every 21 cycles.
  - resp_valid is first high at cycle 148 with resp=8'hFF, unstable=8'h00.
- puf_o[0] drives 1 on votes 1-4 and 0 on votes 5-7, puf_o[1] drives 1 on votes 1-3 only, others 0; each value is held stable through its whole SETTLE window:
  - resp=8'h01, unstable=8'h03.
- Backpressure: after resp_valid, hold resp_ready=0 for 10 cycles and pulse start twice:
  - resp_valid stays 1 and resp/unstable are unchanged.
  - When resp_ready=1, resp_valid drops the next cycle, busy=0, and no second run starts.
- Reset mid-run: clear=0 for one cycle during vote 3 SETTLE:
  - The next cycle shows IDLE, puf_clear=1, busy=0, resp_valid=0.
  - A fresh start with puf_o=8'hA5 yields resp=8'hA5, unstable=8'h00 at cycle 148.
- Back-to-back: start asserted in the handshake cycle is ignored; start one cycle later is accepted, and busy rises the following cycle.
- VOTES=1, SETTLE=2, CLR_CYC=1, puf_o=8'h3C:
  - resp_valid is first high at cycle 5 with resp=8'h3C, unstable=8'h00.
